mem_arb32: RTL and testbench

- Arbiter that shares one single-port synchronous `ram` between the instruction-fetch path and the load/store data path.
- Removes the need for a second `ram` instance for data.
- Grants at most one access per cycle. Data accesses have priority, with a starvation guard that forces a fetch grant.
- Routes the registered read data back to the requester that issued the access, with a one-cycle valid strobe.

---
 rtl/mem_arb32.sv | 110 +++++++++++
 tb/tb_mem_arb32.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb32.sv
// mem_arb32 -- shares one single-port synchronous ram between the
// instruction-fetch path (i_*) and the load/store data path (d_*).
//
// One access is granted per cycle. Data accesses normally win. A pending
// fetch that has been denied STARVE_MAX cycles in a row is forced through
// on the next cycle. Read data comes back from the ram one cycle after the
// grant. It is steered to the port that issued the read, together with a
// one-cycle rvalid strobe.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   i_req, i_addr                 fetch read request
//   i_gnt, i_rvalid, i_rdata      fetch grant and read return
//   d_req, d_we, d_addr, d_wdata  data read/write request
//   d_gnt, d_rvalid, d_rdata      data grant and read return
//   mem_ad, mem_d, mem_we, mem_q  single-port ram interface
//   stall                         fetch pending but not granted
//
// Read-owner FSM:
//   state    | meaning
//   OWN_NONE | no read issued last cycle; mem_q is not returned
//   OWN_I    | fetch read issued last cycle; mem_q goes to i_rdata
//   OWN_D    | data read issued last cycle; mem_q goes to d_rdata
module mem_arb32 #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_ad,
  output logic [DW-1:0] mem_d,
  output logic          mem_we,
  input  logic [DW-1:0] mem_q,
  output logic          stall
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  owner_t        rd_owner, rd_owner_nxt;
  logic [3:0]    starve_cnt, starve_cnt_nxt;
  logic [DW-1:0] i_hold, d_hold;
  logic          force_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_owner   <= OWN_NONE;
      starve_cnt <= 4'd0;
      i_hold     <= '0;
      d_hold     <= '0;
    end else begin
      rd_owner   <= rd_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
      // The rdata outputs keep showing the last word returned to each port.
      if (i_rvalid) i_hold <= mem_q;
      if (d_rvalid) d_hold <= mem_q;
    end
  end

  always_comb begin
    force_i        = i_req & (starve_cnt == STARVE_LIM);
    // Grants are held low while reset is asserted. This keeps a write from
    // reaching the ram during reset.
    d_gnt          = ~reset & d_req & ~force_i;
    i_gnt          = ~reset & i_req & ~d_gnt;
    mem_ad         = d_gnt ? d_addr : i_addr;
    mem_d          = d_wdata;
    mem_we         = d_gnt & d_we;
    stall          = i_req & ~i_gnt;

    rd_owner_nxt   = OWN_NONE;
    if (i_gnt)
      rd_owner_nxt = OWN_I;
    else if (d_gnt && !d_we)
      rd_owner_nxt = OWN_D;

    // A fetch that is denied while pending counts up. When the count
    // reaches the limit, force_i blocks d_gnt, so the count never passes
    // STARVE_LIM.
    starve_cnt_nxt = starve_cnt;
    if (!i_req || i_gnt)
      starve_cnt_nxt = 4'd0;
    else if (d_gnt && starve_cnt != STARVE_LIM)
      starve_cnt_nxt = starve_cnt + 4'd1;

    i_rvalid       = (rd_owner == OWN_I);
    d_rvalid       = (rd_owner == OWN_D);
    i_rdata        = i_rvalid ? mem_q : i_hold;
    d_rdata        = d_rvalid ? mem_q : d_hold;
  end

endmodule

// File: tb/tb_mem_arb32.sv
module tb_mem_arb32;

  localparam logic [31:0] W0 = 32'hE3A01001;
  localparam logic [31:0] W1 = 32'hE3A02002;
  localparam logic [31:0] W2 = 32'hE0813002;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] KK = 32'h12345678;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_ad, mem_d, mem_q;
  logic        mem_we, stall;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arb32 #(.AW(32), .DW(32), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ad(mem_ad), .mem_d(mem_d), .mem_we(mem_we), .mem_q(mem_q), .stall(stall)
  );

  // Synchronous single-port ram, 64 words, word-addressed by mem_ad[7:2].
  logic [31:0] ram [64];
  logic        load_ram = 1'b1;

  always @(posedge clk) begin
    if (load_ram) begin
      for (int j = 0; j < 64; j++) ram[j] <= 32'h0;
      ram[0] <= W0;
      ram[1] <= W1;
      ram[2] <= W2;
    end else if (mem_we) begin
      ram[mem_ad[7:2]] <= mem_d;
    end
    mem_q <= ram[mem_ad[7:2]];
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic        eig;
    logic        edg;
    logic        ewe;
    logic [31:0] ead;
    logic        estall;
    logic        eirv;
    logic [31:0] eird;
    logic        edrv;
    logic [31:0] edrd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                     input logic [31:0] da, input logic [31:0] dwd,
                     input logic eig, input logic edg, input logic ewe, input logic [31:0] ead,
                     input logic estall, input logic eirv, input logic [31:0] eird,
                     input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.eig = eig; v.edg = edg; v.ewe = ewe; v.ead = ead; v.estall = estall;
    v.eirv = eirv; v.eird = eird; v.edrv = edrv; v.edrd = edrd;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
  endtask

  initial begin
    // Fetch only (test 2)
    add(1, 32'h0, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h0,  0, 0, W0, 0, 32'h0);
    add(1, 32'h4, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h4,  0, 1, W0, 0, 32'h0);
    add(1, 32'h8, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h8,  0, 1, W1, 0, 32'h0);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 1, W2, 0, 32'h0);
    // Write then read of the same address (test 3)
    add(0, 32'h0, 1, 1, 32'h40, DB,    0, 1, 1, 32'h40, 0, 0, W2, 0, 32'h0);
    add(0, 32'h0, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 0, 0, W2, 0, 32'h0);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 0, W2, 1, DB);
    // Both reading for 8 cycles: D,D,D,I,D,D,D,I (test 4)
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 0, W2, 0, DB);
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 0, W2, 1, DB);
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 0, W2, 1, DB);
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 1, 0, 0, 32'h8,  0, 0, W2, 1, DB);
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 1, W2, 0, DB);
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 0, W2, 1, DB);
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 0, W2, 1, DB);
    add(1, 32'h8, 1, 0, 32'h40, 32'h0, 1, 0, 0, 32'h8,  0, 0, W2, 1, DB);
    // Collision at count 0, then fetch alone clears the count (test 5)
    add(1, 32'h4, 1, 0, 32'h0,  32'h0, 0, 1, 0, 32'h0,  1, 1, W2, 0, DB);
    add(1, 32'h4, 0, 0, 32'h0,  32'h0, 1, 0, 0, 32'h4,  0, 0, W2, 1, W0);
    add(1, 32'h4, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 1, W1, 0, W0);
    add(1, 32'h4, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 0, W1, 1, DB);
    add(1, 32'h4, 1, 0, 32'h40, 32'h0, 0, 1, 0, 32'h40, 1, 0, W1, 1, DB);
    add(1, 32'h4, 1, 0, 32'h40, 32'h0, 1, 0, 0, 32'h4,  0, 0, W1, 1, DB);
    // Idle for four cycles (test 6)
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 1, W1, 0, DB);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 0, W1, 0, DB);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 0, W1, 0, DB);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 0, W1, 0, DB);
    // A held write is denied when fetch is forced, then read back
    add(1, 32'h0, 1, 1, 32'h44, KK,    0, 1, 1, 32'h44, 1, 0, W1, 0, DB);
    add(1, 32'h0, 1, 1, 32'h44, KK,    0, 1, 1, 32'h44, 1, 0, W1, 0, DB);
    add(1, 32'h0, 1, 1, 32'h44, KK,    0, 1, 1, 32'h44, 1, 0, W1, 0, DB);
    add(1, 32'h0, 1, 1, 32'h44, KK,    1, 0, 0, 32'h0,  0, 0, W1, 0, DB);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 1, W0, 0, DB);
    add(0, 32'h0, 1, 0, 32'h44, 32'h0, 0, 1, 0, 32'h44, 0, 0, W0, 0, DB);
    add(0, 32'h0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 32'h0,  0, 0, W0, 1, KK);

    // Reset with both requests asserted: grants must stay low.
    reset = 1'b1;
    drive(1, 32'h0, 1, 1, 32'h40, DB);
    @(posedge clk);
    #1 load_ram = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_i_gnt",    32'(i_gnt),    32'h0);
    chk("rst_d_gnt",    32'(d_gnt),    32'h0);
    chk("rst_mem_we",   32'(mem_we),   32'h0);
    chk("rst_i_rvalid", 32'(i_rvalid), 32'h0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("rst_i_rdata",  i_rdata,       32'h0);
    chk("rst_d_rdata",  d_rdata,       32'h0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;

    // Issue a data read, then assert reset before the edge that would return it.
    @(posedge clk);
    #1 drive(0, 32'h0, 1, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("midrd_d_gnt", 32'(d_gnt), 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midrd_d_rvalid", 32'(d_rvalid), 32'h0);
    chk("midrd_d_rdata",  d_rdata,       32'h0);
    chk("midrd_d_gnt_rst", 32'(d_gnt),   32'h0);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_d_rvalid", 32'(d_rvalid), 32'h0);
    drive(1, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_i_gnt", 32'(i_gnt), 32'h1);
    chk("post_rst_stall", 32'(stall), 32'h0);
    @(posedge clk);
    #1 drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    chk("post_rst_i_rvalid", 32'(i_rvalid), 32'h1);
    chk("post_rst_i_rdata",  i_rdata,       W0);

    // Table-driven cycles: drive after the rising edge, check at the falling edge.
    for (int k = 0; k < vq.size(); k++) begin
      @(posedge clk);
      #1 drive(vq[k].ir, vq[k].ia, vq[k].dr, vq[k].dw, vq[k].da, vq[k].dwd);
      @(negedge clk);
      chk($sformatf("v%0d_i_gnt", k),    32'(i_gnt),    32'(vq[k].eig));
      chk($sformatf("v%0d_d_gnt", k),    32'(d_gnt),    32'(vq[k].edg));
      chk($sformatf("v%0d_mem_we", k),   32'(mem_we),   32'(vq[k].ewe));
      chk($sformatf("v%0d_mem_ad", k),   mem_ad,        vq[k].ead);
      chk($sformatf("v%0d_stall", k),    32'(stall),    32'(vq[k].estall));
      chk($sformatf("v%0d_i_rvalid", k), 32'(i_rvalid), 32'(vq[k].eirv));
      chk($sformatf("v%0d_i_rdata", k),  i_rdata,       vq[k].eird);
      chk($sformatf("v%0d_d_rvalid", k), 32'(d_rvalid), 32'(vq[k].edrv));
      chk($sformatf("v%0d_d_rdata", k),  d_rdata,       vq[k].edrd);
      if (vq[k].dw && vq[k].dr)
        chk($sformatf("v%0d_mem_d", k), mem_d, vq[k].dwd);
      if (k == 24)
        chk("idle_starve_cnt", 32'(dut.starve_cnt), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
